// File: rtl/sccb_target_emu_if.sv
// SCCB target emulator bus bundle: the two SCCB line levels seen by the
// target, the open-drain pull-down enable, and the write-commit report.
// master: drives the line levels and observes the target.
// slave : the target itself.
interface sccb_target_emu_if;
  logic       sioc_i;
  logic       siod_i;
  logic       siod_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport master (
    output sioc_i, siod_i,
    input  siod_oe, wr_valid, wr_addr, wr_data, busy
  );

  modport slave (
    input  sioc_i, siod_i,
    output siod_oe, wr_valid, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/sccb_target_emu.sv
// SCCB target emulator: answers 3-phase writes and 2-phase write + 2-phase
// read transactions against an internal 2**ADDR_W x 8 register file.
// Both SCCB lines are oversampled on PCLK; sio_d is only ever pulled low.
// Optional feature macro: SCCB_TARGET_ACK_EN -- when defined, the target
// pulls sio_d low for the 9th bit after a matching ID, the sub-address and
// the write data, emulating a camera ACK.
module sccb_target_emu #(
  parameter logic [7:0] DEV_ID = 8'h42,
  parameter int         ADDR_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  sccb_target_emu_if.slave  bus
);

`ifdef SCCB_TARGET_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_X, S_SUB, S_SUB_X,
    S_WDAT, S_WDAT_X, S_RDAT, S_RDAT_X, S_IGNORE
  } state_t;

  state_t r_state, w_state_nxt;

  logic       r_sioc_s1, r_sioc_s2, r_sioc_h;
  logic       r_siod_s1, r_siod_s2, r_siod_h;
  logic [7:0] r_shift;
  logic [3:0] r_cnt;
  logic [7:0] r_sub_addr;
  logic       r_oe, r_busy, r_wr_valid;
  logic [7:0] r_wr_addr, r_wr_data;
  logic [7:0] r_regs [DEPTH];

  logic       w_sioc_rise, w_sioc_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic       w_id_match, w_last_bit;
  logic       w_oe_nxt, w_busy_nxt;
  logic       w_shift_en, w_sub_fire, w_wr_fire, w_rd_load, w_rd_shift;

  // Two-flop synchronizer plus history flop per line; idle bus level is high.
  always_ff @(posedge PCLK or posedge PRESET) begin
    // NOTE: sequential state is assigned with <= so every flop sees pre-edge values.
    if (PRESET) begin
      r_sioc_s1 <= 1'b1;
      r_sioc_s2 <= 1'b1;
      r_sioc_h  <= 1'b1;
      r_siod_s1 <= 1'b1;
      r_siod_s2 <= 1'b1;
      r_siod_h  <= 1'b1;
    end else begin
      r_sioc_s1 <= bus.sioc_i;
      r_sioc_s2 <= r_sioc_s1;
      r_sioc_h  <= r_sioc_s2;
      r_siod_s1 <= bus.siod_i;
      r_siod_s2 <= r_siod_s1;
      r_siod_h  <= r_siod_s2;
    end
  end

  assign w_sioc_rise = r_sioc_s2 & ~r_sioc_h;
  assign w_sioc_fall = ~r_sioc_s2 & r_sioc_h;
  assign w_start     = r_sioc_s2 & ~r_siod_s2 & r_siod_h;
  assign w_stop      = r_sioc_s2 & r_siod_s2 & ~r_siod_h;
  assign w_byte      = {r_shift[6:0], r_siod_s2};
  assign w_id_match  = (r_shift[7:1] == DEV_ID[7:1]);
  assign w_last_bit  = (r_cnt == 4'd7);

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: STOP beats START beats any sioc edge.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ID;
    end else begin
      case (r_state)
        S_ID:     if (w_sioc_rise && w_last_bit) w_state_nxt = S_ID_X;
        S_ID_X:   if (w_sioc_rise) begin
                    if (!w_id_match)     w_state_nxt = S_IGNORE;
                    else if (r_shift[0]) w_state_nxt = S_RDAT;
                    else                 w_state_nxt = S_SUB;
                  end
        S_SUB:    if (w_sioc_rise && w_last_bit) w_state_nxt = S_SUB_X;
        S_SUB_X:  if (w_sioc_rise) w_state_nxt = S_WDAT;
        S_WDAT:   if (w_sioc_rise && w_last_bit) w_state_nxt = S_WDAT_X;
        S_WDAT_X: if (w_sioc_rise) w_state_nxt = S_IGNORE;
        S_RDAT:   if (w_sioc_fall && r_cnt == 4'd8) w_state_nxt = S_RDAT_X;
        S_RDAT_X: if (w_sioc_rise) w_state_nxt = S_IGNORE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // Output/control decode: sampling on sioc rise, driving on sioc fall.
  always_comb begin
    w_oe_nxt   = r_oe;
    w_busy_nxt = r_busy;
    w_shift_en = 1'b0;
    w_sub_fire = 1'b0;
    w_wr_fire  = 1'b0;
    w_rd_load  = 1'b0;
    w_rd_shift = 1'b0;
    if (w_stop) begin
      w_oe_nxt   = 1'b0;
      w_busy_nxt = 1'b0;
    end else if (w_start) begin
      w_busy_nxt = 1'b1;
    end else begin
      if (w_sioc_rise) begin
        case (r_state)
          S_ID:    w_shift_en = 1'b1;
          S_SUB:   begin w_shift_en = 1'b1; w_sub_fire = w_last_bit; end
          S_WDAT:  begin w_shift_en = 1'b1; w_wr_fire  = w_last_bit; end
          S_ID_X:  w_rd_load = w_id_match & r_shift[0];
          default: ;
        endcase
      end
      if (w_sioc_fall) begin
        case (r_state)
          S_ID_X:             w_oe_nxt = ACK_EN & w_id_match;
          S_SUB_X, S_WDAT_X:  w_oe_nxt = ACK_EN;
          S_RDAT: begin
            if (r_cnt == 4'd8) begin
              w_oe_nxt = 1'b0;
            end else begin
              w_oe_nxt   = ~r_shift[7];
              w_rd_shift = 1'b1;
            end
          end
          default:            w_oe_nxt = 1'b0;
        endcase
      end
    end
  end

  // Datapath: shift register, bit counter, sub-address and output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_shift    <= 8'h00;
      r_cnt      <= 4'd0;
      r_sub_addr <= 8'h00;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
    end else begin
      r_oe       <= w_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_valid <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= r_sub_addr;
        r_wr_data <= w_byte;
      end
      if (w_sub_fire) r_sub_addr <= w_byte;
      if (w_start || w_stop) begin
        r_cnt <= 4'd0;
      end else if (w_shift_en) begin
        r_shift <= w_byte;
        r_cnt   <= w_last_bit ? 4'd0 : r_cnt + 4'd1;
      end else if (w_rd_load) begin
        r_shift <= r_regs[r_sub_addr[ADDR_W-1:0]];
        r_cnt   <= 4'd0;
      end else if (w_rd_shift) begin
        r_shift <= {r_shift[6:0], 1'b0};
        r_cnt   <= r_cnt + 4'd1;
      end
    end
  end

  // Register file, written once per committed 3-phase write.
  always_ff @(posedge PCLK or posedge PRESET) begin
    // NOTE: the memory is reset because reads after reset must return 8'h00; this keeps it in flops, not RAM.
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'h00;
    end else if (w_wr_fire) begin
      r_regs[r_sub_addr[ADDR_W-1:0]] <= w_byte;
    end
  end

  assign bus.siod_oe  = r_oe;
  assign bus.busy     = r_busy;
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;

endmodule

// File: tb/tb_sccb_target_emu.sv
// Testbench for sccb_target_emu: an SCCB master bit-bangs transactions on
// an open-drain line model and compares the target's behaviour against a
// register-file reference model. Honours SCCB_TARGET_ACK_EN like the DUT.
module tb_sccb_target_emu;

`ifdef SCCB_TARGET_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  localparam int Q = 4;  // PCLK cycles per quarter SCCB bit

  logic PCLK = 1'b0;
  logic PRESET;
  logic m_scl, m_sda;

  sccb_target_emu_if u_if ();

  assign u_if.sioc_i = m_scl;
  assign u_if.siod_i = m_sda & ~u_if.siod_oe;

  sccb_target_emu #(.DEV_ID(8'h42), .ADDR_W(8)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (u_if)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_regs [256];
  logic [7:0]  m_sub;
  logic [15:0] ev_q [$];
  logic        oe_any;

  always @(negedge PCLK) begin
    if (u_if.wr_valid === 1'b1) ev_q.push_back({u_if.wr_addr, u_if.wr_data});
    if (u_if.siod_oe === 1'b1) oe_any = 1'b1;
  end

  initial begin
    repeat (200000) @(posedge PCLK);
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  function automatic bit id_hit(input logic [7:0] id);
    return id[7:1] == 7'h21;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    m_sub = 8'h00;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic m_bit(input logic b, output logic oe, output logic line);
    m_sda = b;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    @(negedge PCLK);
    oe   = u_if.siod_oe;
    line = u_if.siod_i;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  // oe_v[8:1] = data bits MSB..LSB, oe_v[0] = 9th bit
  task automatic m_byte(input logic [7:0] b, output logic [8:0] oe_v, output logic [7:0] line_v);
    logic o, l;
    for (int i = 7; i >= 0; i--) begin
      m_bit(b[i], o, l);
      oe_v[i+1] = o;
      line_v[i] = l;
    end
    m_bit(1'b1, o, l);
    oe_v[0] = o;
  endtask

  task automatic m_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  // Full 3-phase write with inline comparisons against the model.
  task automatic chk_write3(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] dat);
    logic [8:0] o_id, o_sub, o_dat, e_id, e_ack;
    logic [7:0] l;
    logic       bm;
    int         n0;
    bit         hit;
    n0 = ev_q.size();
    oe_any = 1'b0;
    m_start();
    m_byte(id, o_id, l);
    bm = u_if.busy;
    m_byte(sub, o_sub, l);
    m_byte(dat, o_dat, l);
    m_stop();
    wait_clk(3);
    @(negedge PCLK);
    hit   = id_hit(id) && !id[0];
    e_id  = {8'h00, ACK && id_hit(id)};
    e_ack = {8'h00, ACK && hit};
    checks++; if (o_id !== e_id)   begin failures++; $display("FAIL w3_id_oe id=%h: got %b want %b", id, o_id, e_id); end
    checks++; if (o_sub !== e_ack) begin failures++; $display("FAIL w3_sub_oe id=%h: got %b want %b", id, o_sub, e_ack); end
    checks++; if (o_dat !== e_ack) begin failures++; $display("FAIL w3_dat_oe id=%h: got %b want %b", id, o_dat, e_ack); end
    checks++; if (bm !== 1'b1)     begin failures++; $display("FAIL w3_busy_mid: got %b want 1", bm); end
    checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL w3_busy_after: got %b want 0", u_if.busy); end
    checks++; if (oe_any !== (ACK && id_hit(id))) begin failures++; $display("FAIL w3_oe_any id=%h: got %b want %b", id, oe_any, ACK && id_hit(id)); end
    if (hit) begin
      m_sub = sub;
      m_regs[sub] = dat;
      checks++;
      if (ev_q.size() !== n0 + 1) begin
        failures++; $display("FAIL w3_wr_count: got %0d want %0d", ev_q.size() - n0, 1);
      end else if (ev_q[n0] !== {sub, dat}) begin
        failures++; $display("FAIL w3_wr_event: got %h want %h", ev_q[n0], {sub, dat});
      end
    end else begin
      checks++;
      if (ev_q.size() !== n0) begin failures++; $display("FAIL w3_no_write id=%h: got %0d events want 0", id, ev_q.size() - n0); end
    end
  endtask

  // 2-phase write (sub-address only).
  task automatic chk_write2(input logic [7:0] sub);
    logic [8:0] o_id, o_sub, e_ack;
    logic [7:0] l;
    int         n0;
    n0 = ev_q.size();
    m_start();
    m_byte(8'h42, o_id, l);
    m_byte(sub, o_sub, l);
    m_stop();
    wait_clk(3);
    m_sub = sub;
    e_ack = {8'h00, ACK};
    checks++; if (o_id !== e_ack)  begin failures++; $display("FAIL w2_id_oe: got %b want %b", o_id, e_ack); end
    checks++; if (o_sub !== e_ack) begin failures++; $display("FAIL w2_sub_oe: got %b want %b", o_sub, e_ack); end
    checks++; if (ev_q.size() !== n0) begin failures++; $display("FAIL w2_no_write: got %0d events want 0", ev_q.size() - n0); end
  endtask

  // 2-phase read of the current sub-address.
  task automatic chk_read();
    logic [8:0] o_id, o_dat, e_dat, e_id;
    logic [7:0] l, line;
    logic [7:0] exp;
    m_start();
    m_byte(8'h43, o_id, l);
    m_byte(8'hFF, o_dat, line);
    m_stop();
    wait_clk(3);
    @(negedge PCLK);
    exp   = m_regs[m_sub];
    e_dat = {~exp, 1'b0};
    e_id  = {8'h00, ACK};
    checks++; if (o_id !== e_id)   begin failures++; $display("FAIL rd_id_oe: got %b want %b", o_id, e_id); end
    checks++; if (line !== exp)    begin failures++; $display("FAIL rd_data sub=%h: got %h want %h", m_sub, line, exp); end
    checks++; if (o_dat !== e_dat) begin failures++; $display("FAIL rd_oe_pattern sub=%h: got %b want %b", m_sub, o_dat, e_dat); end
    checks++; if (u_if.siod_oe !== 1'b0 || u_if.busy !== 1'b0) begin
      failures++; $display("FAIL rd_after: got oe=%b busy=%b want 0 0", u_if.siod_oe, u_if.busy);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    m_scl  = 1'b1;
    m_sda  = 1'b1;
    model_reset();
    wait_clk(3);
    @(negedge PCLK);
    checks++;
    if ({u_if.siod_oe, u_if.wr_valid, u_if.busy, u_if.wr_addr, u_if.wr_data} !== 19'h0) begin
      failures++;
      $display("FAIL reset_outputs: got oe=%b v=%b busy=%b a=%h d=%h want all 0",
               u_if.siod_oe, u_if.wr_valid, u_if.busy, u_if.wr_addr, u_if.wr_data);
    end
    wait_clk(1);
    PRESET = 1'b0;
    wait_clk(4);
    @(negedge PCLK);
    checks++;
    if ({u_if.siod_oe, u_if.wr_valid, u_if.busy} !== 3'b000) begin
      failures++; $display("FAIL reset_release: got oe=%b v=%b busy=%b want 0 0 0", u_if.siod_oe, u_if.wr_valid, u_if.busy);
    end
  endtask

  task automatic test_write();
    chk_write3(8'h42, 8'h12, 8'h80);
    chk_write2(8'h12);
    chk_read();
  endtask

  task automatic test_read_back();
    chk_write3(8'h42, 8'h3A, 8'h5C);
    chk_write2(8'h3A);
    chk_read();
  endtask

  task automatic test_id_mismatch();
    chk_write3(8'h60, 8'h01, 8'hFF);
    chk_write2(8'h01);
    chk_read();
  endtask

  task automatic test_repeated_start();
    logic [8:0] o1, o2, o3, o4, e_ack;
    logic [7:0] l, line;
    logic       bm, o, lb;
    int         n0;
    n0 = ev_q.size();
    m_start();
    m_byte(8'h42, o1, l);
    m_byte(8'h12, o2, l);
    m_start();
    bm = u_if.busy;
    m_byte(8'h43, o3, l);
    m_byte(8'hFF, o4, line);
    m_stop();
    wait_clk(3);
    m_sub = 8'h12;
    e_ack = {8'h00, ACK};
    checks++; if (bm !== 1'b1) begin failures++; $display("FAIL rs_busy: got %b want 1", bm); end
    checks++; if (o2 !== e_ack) begin failures++; $display("FAIL rs_sub_oe: got %b want %b", o2, e_ack); end
    checks++; if (o3 !== e_ack) begin failures++; $display("FAIL rs_id_oe: got %b want %b", o3, e_ack); end
    checks++; if (line !== m_regs[8'h12]) begin failures++; $display("FAIL rs_read: got %h want %h", line, m_regs[8'h12]); end
    checks++; if (o4 !== {~m_regs[8'h12], 1'b0}) begin failures++; $display("FAIL rs_read_oe: got %b want %b", o4, {~m_regs[8'h12], 1'b0}); end
    // STOP after four data bits: no write, line released.
    oe_any = 1'b0;
    m_start();
    m_byte(8'h42, o1, l);
    m_byte(8'h12, o2, l);
    for (int i = 0; i < 4; i++) m_bit(1'($urandom_range(0, 1)), o, lb);
    m_stop();
    wait_clk(3);
    @(negedge PCLK);
    checks++; if (ev_q.size() !== n0) begin failures++; $display("FAIL stop4_no_write: got %0d events want 0", ev_q.size() - n0); end
    checks++; if (u_if.siod_oe !== 1'b0 || u_if.busy !== 1'b0) begin
      failures++; $display("FAIL stop4_idle: got oe=%b busy=%b want 0 0", u_if.siod_oe, u_if.busy);
    end
    checks++; if (oe_any !== ACK) begin failures++; $display("FAIL stop4_oe_any: got %b want %b", oe_any, ACK); end
    chk_read();
  endtask

  task automatic test_random();
    logic [7:0] id, sub, dat;
    int op;
    for (int it = 0; it < 24; it++) begin
      op  = int'($urandom_range(0, 3));
      sub = 8'($urandom_range(0, 15));
      dat = 8'($urandom);
      case (op)
        0: chk_write3(8'h42, sub, dat);
        1: begin chk_write2(sub); chk_read(); end
        2: begin
             id = 8'($urandom);
             if (id[7:1] == 7'h21) id = id ^ 8'h80;
             chk_write3(id, sub, dat);
           end
        default: chk_read();
      endcase
    end
  endtask

  task automatic test_back_to_back();
    chk_write3(8'h42, 8'hC3, 8'h0F);
    chk_write3(8'h42, 8'hC3, 8'hF0);
    chk_read();
  endtask

  task automatic test_reset_mid_read();
    logic [8:0] o;
    logic [7:0] l;
    logic       ob, lb, oe_b3;
    chk_write3(8'h42, 8'h33, 8'hA5);
    chk_write2(8'h33);
    m_start();
    m_byte(8'h43, o, l);
    for (int i = 0; i < 4; i++) m_bit(1'b1, ob, lb);
    m_sda = 1'b1;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(1);
    @(negedge PCLK);
    oe_b3 = u_if.siod_oe;
    checks++; if (oe_b3 !== 1'b1) begin failures++; $display("FAIL rst_mid_bit3_oe: got %b want 1", oe_b3); end
    PRESET = 1'b1;
    #1;
    checks++; if (u_if.siod_oe !== 1'b0 || u_if.busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_release: got oe=%b busy=%b want 0 0", u_if.siod_oe, u_if.busy);
    end
    model_reset();
    wait_clk(3);
    PRESET = 1'b0;
    wait_clk(4);
    chk_read();
    chk_write2(8'h33);
    chk_read();
    chk_write2(8'h12);
    chk_read();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_back();
    test_id_mismatch();
    test_repeated_start();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
